// File: rtl/hsem_regfile_if.sv
// BIU-side register access bus for the semaphore register file.
// The BIU drives the strobes, address, data and master ID; the register file returns read data.
interface hsem_regfile_if;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] ihwdata;
    logic [3:0]  master_id;
    logic [31:0] ihrdata;

    modport master (output wr_en, rd_en, reg_addr, ihwdata, master_id, input ihrdata);
    modport slave  (input wr_en, rd_en, reg_addr, ihwdata, master_id, output ihrdata);
endinterface

// File: rtl/hsem_regfile.sv
// Hardware semaphore register file: two-step and one-step locking, keyed per-core clear-all
// and a maskable unlock interrupt. Each semaphore is a hsem_cell.
module hsem_cell (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        sel_wr_i,
    input  logic        sel_rl_i,
    input  logic        clr_i,
    input  logic        lock_bit_i,
    input  logic [7:0]  proc_i,
    input  logic [3:0]  master_id_i,
    input  logic [3:0]  clr_core_i,
    output logic [31:0] sem_o,
    output logic        unlock_o
);
    typedef struct packed {
        logic       lock;
        logic [3:0] core;
        logic [7:0] proc;
    } sem_t;

    sem_t sem_q, sem_d;
    logic owner_match;

    assign owner_match = sem_q.lock && (sem_q.core == master_id_i) && (sem_q.proc == proc_i);

    always_comb begin
        sem_d    = sem_q;
        unlock_o = 1'b0;
        if (sel_wr_i) begin
            // A lock attempt on a held semaphore is ignored even for the current owner.
            if (lock_bit_i) begin
                if (!sem_q.lock) sem_d = '{lock: 1'b1, core: master_id_i, proc: proc_i};
            end else if (owner_match) begin
                sem_d    = '0;
                unlock_o = 1'b1;
            end
        end
        if (sel_rl_i && !sem_q.lock) sem_d = '{lock: 1'b1, core: master_id_i, proc: 8'h00};
        if (clr_i && sem_q.lock && (sem_q.core == clr_core_i)) begin
            sem_d    = '0;
            unlock_o = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) sem_q <= '0;
        else          sem_q <= sem_d;
    end

    assign sem_o = {sem_q.lock, 19'b0, sem_q.core, sem_q.proc};
endmodule

module hsem_regfile #(
    parameter int          NUM_SEM = 16,
    parameter logic [15:0] CLR_KEY = 16'hA5A5
) (
    input  logic           hclk,
    input  logic           hresetn,
    hsem_regfile_if.slave  bus,
    output logic           irq
);
    localparam logic [5:0] A_IER  = 6'h20;
    localparam logic [5:0] A_ICR  = 6'h21;
    localparam logic [5:0] A_ISR  = 6'h22;
    localparam logic [5:0] A_MISR = 6'h23;
    localparam logic [5:0] A_CR   = 6'h24;
    localparam logic [5:0] A_KEYR = 6'h25;

    logic [5:0]              word;
    logic [3:0]              idx;
    logic                    idx_ok, in_r, in_rlr, cr_fire;
    logic [15:0][31:0]       sem_w;
    logic [NUM_SEM-1:0]      unlock_w;
    logic [NUM_SEM-1:0]      ier_q, ier_d, isr_q, isr_d;
    logic [15:0]             keyr_q, keyr_d;
    logic                    irq_q;
    logic [31:0]             rdata;
    logic                    unused_addr;

    assign word        = bus.reg_addr[7:2];
    assign idx         = word[3:0];
    assign idx_ok      = {1'b0, idx} < 5'(NUM_SEM);
    assign in_r        = (word[5:4] == 2'b00) && idx_ok;
    assign in_rlr      = (word[5:4] == 2'b01) && idx_ok;
    assign unused_addr = ^bus.reg_addr[1:0];

    assign cr_fire = bus.wr_en && (word == A_CR) && (bus.ihwdata[31:16] == keyr_q) && (keyr_q == CLR_KEY);

    // Slots above NUM_SEM read as zero words so the read mux can index all 16 positions.
    for (genvar i = 0; i < 16; i++) begin : g_sem
        if (i < NUM_SEM) begin : g_cell
            hsem_cell u_cell (
                .hclk        (hclk),
                .hresetn     (hresetn),
                .sel_wr_i    (bus.wr_en && in_r && (idx == 4'(i))),
                .sel_rl_i    (bus.rd_en && in_rlr && (idx == 4'(i))),
                .clr_i       (cr_fire),
                .lock_bit_i  (bus.ihwdata[31]),
                .proc_i      (bus.ihwdata[7:0]),
                .master_id_i (bus.master_id),
                .clr_core_i  (bus.ihwdata[11:8]),
                .sem_o       (sem_w[i]),
                .unlock_o    (unlock_w[i])
            );
        end else begin : g_pad
            assign sem_w[i] = '0;
        end
    end

    always_comb begin
        ier_d  = ier_q;
        isr_d  = isr_q;
        keyr_d = keyr_q;
        if (bus.wr_en) begin
            if (word == A_IER)  ier_d  = bus.ihwdata[NUM_SEM-1:0];
            if (word == A_ICR)  isr_d  = isr_q & ~bus.ihwdata[NUM_SEM-1:0];
            if (word == A_KEYR) keyr_d = bus.ihwdata[31:16];
        end
        isr_d = isr_d | unlock_w;
    end

    // irq follows the registered ISR/IER, so it lags their update by one cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ier_q  <= '0;
            isr_q  <= '0;
            keyr_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ier_q  <= ier_d;
            isr_q  <= isr_d;
            keyr_q <= keyr_d;
            irq_q  <= |(isr_q & ier_q);
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.rd_en) begin
            if (in_r) begin
                rdata = sem_w[idx];
            end else if (in_rlr) begin
                rdata = sem_w[idx][31] ? sem_w[idx] : {1'b1, 19'b0, bus.master_id, 8'h00};
            end else begin
                case (word)
                    A_IER:   rdata = 32'(ier_q);
                    A_ISR:   rdata = 32'(isr_q);
                    A_MISR:  rdata = 32'(isr_q & ier_q);
                    A_KEYR:  rdata = {keyr_q, 16'h0000};
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign bus.ihrdata = rdata;
    assign irq         = irq_q;
endmodule

// File: tb/tb_hsem_regfile.sv
// Directed bench for hsem_regfile: a per-cycle compare against an array-based semaphore model,
// plus literal expectations taken from the semaphore rules.
module tb_hsem_regfile;
    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    logic irq;
    int   checks = 0;
    int   failures = 0;

    hsem_regfile_if bus ();
    hsem_regfile #(.NUM_SEM(16), .CLR_KEY(16'hA5A5)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus),
        .irq     (irq)
    );

    always #5 hclk = ~hclk;

    // ---------------- model ----------------
    bit          m_lock [16];
    logic [3:0]  m_core [16];
    logic [7:0]  m_proc [16];
    logic [15:0] m_ier, m_isr, m_keyr;
    bit          m_irq;

    function automatic logic [31:0] m_word(input int i);
        return {m_lock[i], 19'b0, m_core[i], m_proc[i]};
    endfunction

    function automatic logic [31:0] model_rd();
        int a;
        if (!bus.rd_en) return 32'h0;
        a = int'(bus.reg_addr) / 4;
        if (a < 16) return m_word(a);
        if (a < 32) return m_lock[a-16] ? m_word(a-16) : {1'b1, 19'b0, bus.master_id, 8'h00};
        case (a)
            32: return {16'h0, m_ier};
            34: return {16'h0, m_isr};
            35: return {16'h0, m_isr & m_ier};
            37: return {m_keyr, 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [15:0] clr_mask(input logic [31:0] d);
        logic [15:0] m = '0;
        if (d[31:16] == m_keyr && m_keyr == 16'hA5A5)
            for (int i = 0; i < 16; i++) m[i] = m_lock[i] && m_core[i] == d[11:8];
        return m;
    endfunction

    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < 16; i++) begin
                m_lock[i] <= 1'b0; m_core[i] <= '0; m_proc[i] <= '0;
            end
            m_ier <= '0; m_isr <= '0; m_keyr <= '0; m_irq <= 1'b0;
        end else begin
            int a;
            logic [31:0] d;
            logic [15:0] cm;
            a  = int'(bus.reg_addr) / 4;
            d  = bus.ihwdata;
            cm = clr_mask(d);
            m_irq <= |(m_isr & m_ier);
            if (bus.wr_en) begin
                if (a < 16) begin
                    if (d[31] && !m_lock[a]) begin
                        m_lock[a] <= 1'b1; m_core[a] <= bus.master_id; m_proc[a] <= d[7:0];
                    end else if (!d[31] && m_lock[a] && m_core[a] == bus.master_id && m_proc[a] == d[7:0]) begin
                        m_lock[a] <= 1'b0; m_core[a] <= '0; m_proc[a] <= '0;
                        m_isr <= m_isr | (16'h1 << a);
                    end
                end else if (a == 32) m_ier <= d[15:0];
                else if (a == 33) m_isr <= m_isr & ~d[15:0];
                else if (a == 37) m_keyr <= d[31:16];
                else if (a == 36 && cm != 0) begin
                    for (int i = 0; i < 16; i++)
                        if (cm[i]) begin m_lock[i] <= 1'b0; m_core[i] <= '0; m_proc[i] <= '0; end
                    m_isr <= m_isr | cm;
                end
            end else if (bus.rd_en && a >= 16 && a < 32 && !m_lock[a-16]) begin
                m_lock[a-16] <= 1'b1; m_core[a-16] <= bus.master_id; m_proc[a-16] <= 8'h00;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge hclk) begin
        if (hresetn) begin
            checks++;
            if (bus.ihrdata !== model_rd()) begin
                failures++;
                $display("FAIL cyc_rdata addr=%h actual=%h required=%h", bus.reg_addr, bus.ihrdata, model_rd());
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL cyc_irq actual=%b required=%b", irq, m_irq);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge hclk); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] mid);
        bus.wr_en = 1'b1; bus.reg_addr = a; bus.ihwdata = d; bus.master_id = mid;
        sync();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [3:0] mid, input logic [31:0] exp);
        bus.rd_en = 1'b1; bus.reg_addr = a; bus.master_id = mid;
        @(negedge hclk);
        chk(nm, bus.ihrdata, exp);
        sync();
        bus.rd_en = 1'b0;
    endtask

    task automatic irq_chk(input string nm, input logic exp);
        @(negedge hclk);
        chk(nm, {31'b0, irq}, {31'b0, exp});
        sync();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.reg_addr = '0; bus.ihwdata = '0; bus.master_id = '0;
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        sync();

        rd_chk("rst_r0", 8'h00, 4'h0, 32'h0);
        rd_chk("rst_isr", 8'h88, 4'h0, 32'h0);
        irq_chk("rst_irq", 1'b0);

        // two-step lock; re-lock by the same owner is ignored
        wr(8'h0C, 32'h8000_0011, 4'h2);
        rd_chk("lock_r3", 8'h0C, 4'h0, 32'h8000_0211);
        wr(8'h0C, 32'h8000_0055, 4'h2);
        rd_chk("relock_r3", 8'h0C, 4'h0, 32'h8000_0211);

        // unlock: wrong master ignored, owner releases and sets ISR
        wr(8'h0C, 32'h0000_0011, 4'h1);
        rd_chk("badown_r3", 8'h0C, 4'h0, 32'h8000_0211);
        rd_chk("badown_isr", 8'h88, 4'h0, 32'h0);
        wr(8'h0C, 32'h0000_0011, 4'h2);
        rd_chk("unlock_r3", 8'h0C, 4'h0, 32'h0);
        rd_chk("unlock_isr", 8'h88, 4'h0, 32'h0000_0008);
        irq_chk("masked_irq", 1'b0);
        wr(8'h84, 32'h0000_0008, 4'h0);

        // one-step read lock
        rd_chk("rlr0_m5", 8'h40, 4'h5, 32'h8000_0500);
        rd_chk("r0_after", 8'h00, 4'h0, 32'h8000_0500);
        rd_chk("rlr0_m6", 8'h40, 4'h6, 32'h8000_0500);

        // interrupt timing
        wr(8'h80, 32'h0000_0008, 4'h0);
        wr(8'h0C, 32'h8000_0011, 4'h2);
        wr(8'h0C, 32'h0000_0011, 4'h2);
        irq_chk("irq_lag", 1'b0);
        irq_chk("irq_rise", 1'b1);
        rd_chk("misr_set", 8'h8C, 4'h0, 32'h0000_0008);
        wr(8'h84, 32'h0000_0008, 4'h0);
        irq_chk("irq_hold", 1'b1);
        irq_chk("irq_fall", 1'b0);
        rd_chk("misr_clr", 8'h8C, 4'h0, 32'h0);

        // clear-all
        wr(8'h80, 32'h0, 4'h0);
        wr(8'h04, 32'h8000_0001, 4'h3);
        wr(8'h10, 32'h8000_0004, 4'h3);
        wr(8'h08, 32'h8000_0002, 4'h1);
        wr(8'h94, 32'hA5A5_0000, 4'h0);
        wr(8'h90, 32'h5A5A_0300, 4'h0);
        rd_chk("badkey_r1", 8'h04, 4'h0, 32'h8000_0301);
        rd_chk("badkey_isr", 8'h88, 4'h0, 32'h0);
        wr(8'h90, 32'hA5A5_0300, 4'h0);
        rd_chk("clr_r1", 8'h04, 4'h0, 32'h0);
        rd_chk("clr_r4", 8'h10, 4'h0, 32'h0);
        rd_chk("clr_r2", 8'h08, 4'h0, 32'h8000_0102);
        rd_chk("clr_isr", 8'h88, 4'h0, 32'h0000_0012);

        // top slot, unmapped access
        wr(8'h3C, 32'h8000_00FF, 4'hF);
        rd_chk("r15", 8'h3C, 4'h0, 32'h8000_0FFF);
        wr(8'hF0, 32'hFFFF_FFFF, 4'h0);
        rd_chk("unmapped_f0", 8'hF0, 4'h0, 32'h0);
        rd_chk("cr_wo", 8'h90, 4'h0, 32'h0);

        // reset while locked with irq pending
        wr(8'h80, 32'h0000_0004, 4'h0);
        wr(8'h08, 32'h0000_0002, 4'h1);
        sync();
        irq_chk("pre_rst_irq", 1'b1);
        #2 hresetn = 1'b0;
        #1 chk("rst_async_irq", {31'b0, irq}, 32'h0);
        sync();
        hresetn = 1'b1;
        sync();
        rd_chk("post_r0", 8'h00, 4'h0, 32'h0);
        rd_chk("post_r15", 8'h3C, 4'h0, 32'h0);
        rd_chk("post_ier", 8'h80, 4'h0, 32'h0);
        rd_chk("post_isr", 8'h88, 4'h0, 32'h0);
        irq_chk("post_irq", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
